intersection_arbiter: RTL and testbench
=======================================

Name: intersection_arbiter

Overview:
- Schedules the right-of-way at a four-approach intersection (N, S, E, W) and drives the per-approach 3-bit lamp outputs.
- Grants one approach green at a time using round-robin among approaches with vehicles waiting, and skips empty approaches.
- Sizes each green from that approach's 2-bit traffic density.
- Supports emergency-vehicle preemption and sits directly above the lamp drivers.

Parameters:
- BASE_GREEN, 4: green cycles per density step; green length G = BASE_GREEN*(density+1), giving 4/8/12/16 cycles.
- YELLOW_CYC, 4: yellow cycles.
- ALL_RED_CYC, 2: all-red clearance cycles.
- CNT_W, 6: phase timer width; must hold 4*BASE_GREEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_a  in  1  synchronous active-low reset
- req  in  4  vehicle-present flags; bit0=N, bit1=S, bit2=E, bit3=W
- traffic_n / traffic_s / traffic_e / traffic_w  in  2 each  density, 00 low to 11 very high
- emerg_req  in  1  emergency preemption request, level
- emerg_dir  in  2  emergency approach: 0=N, 1=S, 2=E, 3=W
- n_lights / s_lights / e_lights / w_lights  out  3 each  {red,yellow,green}: 100=red, 010=yellow, 001=green
- grant  out  4  one-hot approach currently green or yellow; 0 otherwise
- emerg_ack  out  1  high while the emergency approach is green

Behaviour:
- Reset (rst_a low at a rising edge):
  - state=IDLE, all lights 100, grant=0, emerg_ack=0, timer=0.
  - rr_ptr=3, so N has first priority.
  - Reset wins over any in-progress phase; no yellow is shown.
- All outputs are registered and decoded from state, cur (the 2-bit approach index) and emerg_mode.
- States: IDLE, GREEN, YELLOW, ALL_RED.
- Arbitration (performed in IDLE, and at the last cycle of ALL_RED):
  - emerg_req=1: winner=emerg_dir, set emerg_mode=1, rr_ptr unchanged.
  - Otherwise, if req!=0: winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo 4; rr_ptr<=winner; timer loaded with G-1, using the winner's density sampled that cycle.
  - Otherwise: go to IDLE, all red.
- IDLE: all red. A request sampled at edge t produces green on the winner's lights from edge t; latency is 1 cycle from input to lamp.
- GREEN (normal):
  - Timer decrements each cycle; at timer=0, go to YELLOW. Total green is exactly G cycles.
  - Density changes during green are ignored.
  - Gap-out: if req[cur]=0, at least BASE_GREEN green cycles have elapsed, and any other req bit is set, go to YELLOW at the next edge.
- Preemption:
  - emerg_req=1 with emerg_dir!=cur during normal GREEN: go to YELLOW next edge regardless of timer.
  - During YELLOW or ALL_RED: the current clearance completes; the emergency wins at the next arbitration.
- GREEN (emerg_mode=1):
  - Held indefinitely while emerg_req=1 and emerg_dir==cur; emerg_ack=1.
  - emerg_req falling or emerg_dir changing: go to YELLOW, emerg_ack=0 from that edge, emerg_mode cleared at ALL_RED exit.
  - emerg_req rising with emerg_dir==cur during normal green: switch to emerg_mode in place with no yellow.
- YELLOW: exactly YELLOW_CYC cycles; cur lights 010; grant stays.
- ALL_RED: exactly ALL_RED_CYC cycles; all lights 100; grant=0; then arbitrate.
- Non-granted approaches always show 100. At most one approach is ever non-red.
- Simultaneous events: emergency beats round-robin; gap-out and preemption in the same cycle are one YELLOW transition; reset beats everything.
- emerg_dir is ignored while emerg_req=0.

Decomposition:
- Shared package:
  - lamp constants LAMP_RED/LAMP_YEL/LAMP_GRN
  - state enum
  - approach index constants DIR_N..DIR_W
- One sub-module, rr_pick4: combinational 4-way round-robin picker; inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and valid.

Test Plan:
- Reset: hold rst_a=0 for 3 cycles with req=1111 -> all lights 100, grant=0, emerg_ack=0 throughout; first edge with rst_a=1 grants N.
- Single request: req=0001, traffic_n=10 after reset -> N green exactly 12 cycles, yellow 4, all-red 2, then N green again for 12 cycles.
- Round-robin and skip: req=1101, all densities 00 -> green order N, E, W, N, each 4 cycles; S is never lit.
- Gap-out: N green with traffic_n=11; drop req[0] at green cycle 6 while req[2]=1 -> yellow at cycle 7, E green after 4+2 cycles.
- Preemption: during N green cycle 3, emerg_req=1 with emerg_dir=3 -> yellow 4, all-red 2, W green with emerg_ack=1 held for 30 cycles; drop emerg_req -> W yellow; round-robin resumes from the pre-emergency rr_ptr.
- Mid-operation reset: assert rst_a=0 during yellow -> all 100 at the next edge; no residual yellow or green after release.

Source files
------------

// File: rtl/intersection_arbiter_pkg.sv
// Shared types and constants for the intersection arbiter.
package intersection_arbiter_pkg;

    // Lamp encodings {red,yellow,green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Approach indices, matching req bit positions
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ALL_RED = 2'd3
    } state_t;

    // Lamp value for approach d given the phase and the served approach
    function automatic logic [2:0] lamp_for(input state_t st, input logic [1:0] cur,
                                            input logic [1:0] d);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        if (cur == d) begin
            if (st == ST_GREEN) begin
                lamp = LAMP_GRN;
            end else if (st == ST_YELLOW) begin
                lamp = LAMP_YEL;
            end
        end
        return lamp;
    endfunction

endpackage

// File: rtl/intersection_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set req bit after ptr.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4) and keep the first hit
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/intersection_arbiter.sv
// Four-approach intersection scheduler: round-robin greens sized by density,
// gap-out, and emergency preemption; drives the per-approach lamps.
module intersection_arbiter
    import intersection_arbiter_pkg::*;
#(
    parameter int unsigned BASE_GREEN  = 4,
    parameter int unsigned YELLOW_CYC  = 4,
    parameter int unsigned ALL_RED_CYC = 2,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [3:0] req,
    input  logic [1:0] traffic_n,
    input  logic [1:0] traffic_s,
    input  logic [1:0] traffic_e,
    input  logic [1:0] traffic_w,
    input  logic       emerg_req,
    input  logic [1:0] emerg_dir,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights,
    output logic [3:0] grant,
    output logic       emerg_ack
);

    state_t           state, nxt_state;
    logic [1:0]       cur, nxt_cur;
    logic [1:0]       rr_ptr, nxt_ptr;
    logic             emerg_mode, nxt_emerg;
    logic [CNT_W-1:0] timer, nxt_timer;
    logic [CNT_W-1:0] gcnt, nxt_gcnt;

    logic [2:0]       nxt_n, nxt_s, nxt_e, nxt_w;
    logic [3:0]       nxt_grant;
    logic             nxt_ack;

    logic [1:0]       pick_winner;
    logic             pick_valid;
    logic [1:0]       win_dens;
    logic [CNT_W-1:0] green_load;
    logic [3:0]       cur_oh;
    logic             gap_out;
    logic             arb;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Density of the round-robin winner, sampled in the arbitration cycle
    always_comb begin
        win_dens = traffic_n;
        case (pick_winner)
            DIR_N:   win_dens = traffic_n;
            DIR_S:   win_dens = traffic_s;
            DIR_E:   win_dens = traffic_e;
            DIR_W:   win_dens = traffic_w;
            default: win_dens = traffic_n;
        endcase
    end

    assign green_load = CNT_W'(BASE_GREEN * ({30'd0, win_dens} + 32'd1) - 32'd1);
    assign cur_oh     = 4'(1) << cur;
    // Current approach empty, minimum green served, and someone else waiting
    assign gap_out    = !req[cur] && (gcnt >= CNT_W'(BASE_GREEN - 1)) && (|(req & ~cur_oh));

    // Next-state, arbitration and registered-output decode
    always_comb begin
        nxt_state = state;
        nxt_cur   = cur;
        nxt_ptr   = rr_ptr;
        nxt_emerg = emerg_mode;
        nxt_timer = timer;
        nxt_gcnt  = gcnt;
        arb       = 1'b0;

        case (state)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_GREEN: begin
                if (emerg_mode) begin
                    if (!(emerg_req && emerg_dir == cur)) begin
                        nxt_state = ST_YELLOW;
                        nxt_timer = CNT_W'(YELLOW_CYC - 1);
                    end
                end else begin
                    nxt_timer = timer - CNT_W'(1);
                    nxt_gcnt  = gcnt + CNT_W'(1);
                    if (emerg_req && emerg_dir == cur) begin
                        nxt_emerg = 1'b1;
                    end else if (emerg_req || timer == '0 || gap_out) begin
                        nxt_state = ST_YELLOW;
                        nxt_timer = CNT_W'(YELLOW_CYC - 1);
                    end
                end
            end
            ST_YELLOW: begin
                if (timer == '0) begin
                    nxt_state = ST_ALL_RED;
                    nxt_timer = CNT_W'(ALL_RED_CYC - 1);
                end else begin
                    nxt_timer = timer - CNT_W'(1);
                end
            end
            ST_ALL_RED: begin
                if (timer == '0) begin
                    nxt_emerg = 1'b0;
                    arb       = 1'b1;
                end else begin
                    nxt_timer = timer - CNT_W'(1);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        if (arb) begin
            nxt_gcnt = '0;
            if (emerg_req) begin
                nxt_state = ST_GREEN;
                nxt_cur   = emerg_dir;
                nxt_emerg = 1'b1;
                nxt_timer = '0;
            end else if (pick_valid) begin
                nxt_state = ST_GREEN;
                nxt_cur   = pick_winner;
                nxt_ptr   = pick_winner;
                nxt_emerg = 1'b0;
                nxt_timer = green_load;
            end else begin
                nxt_state = ST_IDLE;
                nxt_emerg = 1'b0;
                nxt_timer = '0;
            end
        end

        nxt_n     = lamp_for(nxt_state, nxt_cur, DIR_N);
        nxt_s     = lamp_for(nxt_state, nxt_cur, DIR_S);
        nxt_e     = lamp_for(nxt_state, nxt_cur, DIR_E);
        nxt_w     = lamp_for(nxt_state, nxt_cur, DIR_W);
        nxt_grant = (nxt_state == ST_GREEN || nxt_state == ST_YELLOW) ? (4'(1) << nxt_cur) : 4'd0;
        nxt_ack   = (nxt_state == ST_GREEN) && nxt_emerg;
    end

    // State and output registers; reset forces all-red immediately
    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state      <= ST_IDLE;
            cur        <= DIR_N;
            rr_ptr     <= DIR_W;
            emerg_mode <= 1'b0;
            timer      <= '0;
            gcnt       <= '0;
            n_lights   <= LAMP_RED;
            s_lights   <= LAMP_RED;
            e_lights   <= LAMP_RED;
            w_lights   <= LAMP_RED;
            grant      <= 4'd0;
            emerg_ack  <= 1'b0;
        end else begin
            state      <= nxt_state;
            cur        <= nxt_cur;
            rr_ptr     <= nxt_ptr;
            emerg_mode <= nxt_emerg;
            timer      <= nxt_timer;
            gcnt       <= nxt_gcnt;
            n_lights   <= nxt_n;
            s_lights   <= nxt_s;
            e_lights   <= nxt_e;
            w_lights   <= nxt_w;
            grant      <= nxt_grant;
            emerg_ack  <= nxt_ack;
        end
    end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter with a cycle-level behavioural model.
module tb_intersection_arbiter;
    import intersection_arbiter_pkg::*;

    localparam int BASE  = 4;
    localparam int YEL_N = 4;
    localparam int RED_N = 2;

    localparam int P_IDLE  = 0;
    localparam int P_GREEN = 1;
    localparam int P_YEL   = 2;
    localparam int P_RED   = 3;

    logic       clk;
    logic       rst_a;
    logic [3:0] req;
    logic [1:0] traffic_n, traffic_s, traffic_e, traffic_w;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic [3:0] grant;
    logic       emerg_ack;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase, served approach, cycles left in clearance, green cycles shown
    int m_phase = P_IDLE;
    int m_dir   = 0;
    int m_ptr   = 3;
    int m_left  = 0;
    int m_shown = 0;
    int m_g     = 0;
    bit m_emerg = 1'b0;
    bit m_valid = 1'b0;

    intersection_arbiter dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .req       (req),
        .traffic_n (traffic_n),
        .traffic_s (traffic_s),
        .traffic_e (traffic_e),
        .traffic_w (traffic_w),
        .emerg_req (emerg_req),
        .emerg_dir (emerg_dir),
        .n_lights  (n_lights),
        .s_lights  (s_lights),
        .e_lights  (e_lights),
        .w_lights  (w_lights),
        .grant     (grant),
        .emerg_ack (emerg_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dens_of(input int d);
        case (d)
            0:       return int'(traffic_n);
            1:       return int'(traffic_s);
            2:       return int'(traffic_e);
            default: return int'(traffic_w);
        endcase
    endfunction

    function automatic logic [2:0] lights_of(input int d);
        case (d)
            0:       return n_lights;
            1:       return s_lights;
            2:       return e_lights;
            default: return w_lights;
        endcase
    endfunction

    function automatic int exp_lamp(input int d);
        if (m_dir == d && m_phase == P_GREEN) return 1;
        if (m_dir == d && m_phase == P_YEL) return 2;
        return 4;
    endfunction

    task automatic m_to_yellow();
        m_phase = P_YEL;
        m_left  = YEL_N;
    endtask

    task automatic m_arb();
        bit found;
        found = 1'b0;
        m_shown = 0;
        if (emerg_req) begin
            m_phase = P_GREEN;
            m_dir   = int'(emerg_dir);
            m_emerg = 1'b1;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                int d;
                d = (m_ptr + i) % 4;
                if (!found && req[d]) begin
                    found   = 1'b1;
                    m_phase = P_GREEN;
                    m_dir   = d;
                    m_ptr   = d;
                    m_emerg = 1'b0;
                    m_g     = BASE * (dens_of(d) + 1);
                end
            end
            if (!found) begin
                m_phase = P_IDLE;
                m_emerg = 1'b0;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic m_step();
        bit others;
        m_valid = 1'b1;
        others  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (d != m_dir && req[d]) others = 1'b1;
        end
        if (!rst_a) begin
            m_phase = P_IDLE;
            m_ptr   = 3;
            m_emerg = 1'b0;
            m_dir   = 0;
        end else begin
            case (m_phase)
                P_IDLE: m_arb();
                P_GREEN: begin
                    if (m_emerg) begin
                        if (!(emerg_req && int'(emerg_dir) == m_dir)) m_to_yellow();
                    end else begin
                        m_shown++;
                        if (emerg_req && int'(emerg_dir) == m_dir) m_emerg = 1'b1;
                        else if (emerg_req) m_to_yellow();
                        else if (m_shown == m_g) m_to_yellow();
                        else if (!req[m_dir] && m_shown >= BASE && others) m_to_yellow();
                    end
                end
                P_YEL: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_RED;
                        m_left  = RED_N;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_emerg = 1'b0;
                        m_arb();
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            m_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_a     = 1'b0;
        emerg_req = 1'b0;
        cyc(1);
        rst_a = 1'b1;
    endtask

    // Count consecutive cycles approach d shows lamp, bounded
    task automatic run_len(input int d, input logic [2:0] lamp, output int len);
        len = 0;
        while (lights_of(d) == lamp && len < 200) begin
            len++;
            cyc(1);
        end
    endtask

    // Compare every DUT output against the model each cycle
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("n_lights", int'(n_lights), exp_lamp(0));
                chk("s_lights", int'(s_lights), exp_lamp(1));
                chk("e_lights", int'(e_lights), exp_lamp(2));
                chk("w_lights", int'(w_lights), exp_lamp(3));
                chk("grant", int'(grant),
                    (m_phase == P_GREEN || m_phase == P_YEL) ? (1 << m_dir) : 0);
                chk("emerg_ack", int'(emerg_ack), (m_phase == P_GREEN && m_emerg) ? 1 : 0);
            end
        end
    end

    initial begin
        int len;
        int ord[4];
        ord = '{0, 2, 3, 0};

        rst_a = 1'b0; req = 4'b1111; emerg_req = 1'b0; emerg_dir = 2'd0;
        traffic_n = 2'd0; traffic_s = 2'd0; traffic_e = 2'd0; traffic_w = 2'd0;

        // Reset held with all requests present
        cyc(3);
        chk("rst_n_red", int'(n_lights), 4);
        chk("rst_grant", int'(grant), 0);
        rst_a = 1'b1;
        cyc(1);
        chk("first_grant_n", int'(grant), 1);
        chk("first_n_green", int'(n_lights), 1);

        // Single request, density 2 -> 12 green, 4 yellow, 2 all-red, 12 green
        req = 4'b0001; traffic_n = 2'd2;
        do_reset();
        cyc(1);
        run_len(0, LAMP_GRN, len); chk("single_green_len", len, 12);
        run_len(0, LAMP_YEL, len); chk("single_yel_len", len, 4);
        run_len(0, LAMP_RED, len); chk("single_red_len", len, 2);
        run_len(0, LAMP_GRN, len); chk("single_green2_len", len, 12);

        // Round-robin with S skipped
        req = 4'b1101; traffic_n = 2'd0;
        do_reset();
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", int'(grant), 1 << ord[k]);
            run_len(ord[k], LAMP_GRN, len);
            chk("rr_len", len, 4);
            if (k < 3) cyc(6);
        end

        // Gap-out at green cycle 6 of a 16-cycle green
        req = 4'b0101; traffic_n = 2'd3;
        do_reset();
        cyc(1);
        cyc(5);
        req = 4'b0100;
        cyc(1);
        chk("gap_n_yellow", int'(n_lights), 2);
        cyc(6);
        chk("gap_e_green", int'(e_lights), 1);

        // Preemption to W during N green cycle 3, then round-robin resumes at S
        req = 4'b0111; traffic_n = 2'd0;
        do_reset();
        cyc(1);
        cyc(2);
        emerg_req = 1'b1; emerg_dir = 2'd3;
        cyc(1);
        chk("pre_n_yellow", int'(n_lights), 2);
        cyc(6);
        chk("pre_w_green", int'(w_lights), 1);
        chk("pre_ack", int'(emerg_ack), 1);
        cyc(29);
        chk("pre_ack_held", int'(emerg_ack), 1);
        emerg_req = 1'b0;
        cyc(1);
        chk("pre_w_yellow", int'(w_lights), 2);
        chk("pre_ack_drop", int'(emerg_ack), 0);
        cyc(6);
        chk("rr_resume_s", int'(grant), 2);

        // Emergency on the approach already green: stays green, no yellow
        req = 4'b0001; emerg_dir = 2'd0;
        do_reset();
        cyc(1);
        emerg_req = 1'b1;
        cyc(1);
        chk("inplace_green", int'(n_lights), 1);
        chk("inplace_ack", int'(emerg_ack), 1);
        cyc(20);
        chk("inplace_hold", int'(n_lights), 1);
        emerg_req = 1'b0;
        cyc(1);
        chk("inplace_yellow", int'(n_lights), 2);

        // Reset during yellow
        req = 4'b0001;
        do_reset();
        cyc(1);
        cyc(4);
        chk("mid_yellow", int'(n_lights), 2);
        rst_a = 1'b0;
        cyc(1);
        chk("mid_rst_red", int'(n_lights), 4);
        chk("mid_rst_grant", int'(grant), 0);
        req = 4'b0000;
        rst_a = 1'b1;
        cyc(3);
        chk("post_rst_n", int'(n_lights), 4);
        chk("post_rst_grant", int'(grant), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
